// File: rtl/ysyx_22040895_pcu.sv
`default_nettype none
// =============================================================================
// Module      : ysyx_22040895_pcu
// Description : Fetch-PC owner. Issues one outstanding instruction-memory
//               request at a time, applies EX branch redirects, drops
//               wrong-path responses and flushes younger stages.
//               Optional perf counters: define YSYX_22040895_PCU_PERF_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module ysyx_22040895_pcu #(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            br_valid_i_pcu,
    input  logic            jump_branch_i_pcu,
    input  logic [XLEN-1:0] dnpc_i_pcu,
    output logic            req_valid_o_pcu,
    input  logic            req_ready_i_pcu,
    output logic [XLEN-1:0] req_addr_o_pcu,
    input  logic            rsp_valid_i_pcu,
    input  logic [31:0]     rsp_inst_i_pcu,
    output logic            inst_valid_o_pcu,
    input  logic            inst_ready_i_pcu,
    output logic [31:0]     inst_o_pcu,
    output logic [XLEN-1:0] inst_pc_o_pcu,
    output logic            flush_o_pcu
`ifdef YSYX_22040895_PCU_PERF_EN
    ,
    output logic [63:0]     perf_fetch_o_pcu,
    output logic [63:0]     perf_redirect_o_pcu,
    output logic [63:0]     perf_drop_o_pcu
`endif
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst_pc_q;
    logic [31:0]     inst_q;
    logic            inst_valid_q;
    logic            drop;
    logic            running;

    logic            redirect;
    logic            req_fire;

    assign redirect = br_valid_i_pcu & jump_branch_i_pcu;

    // running keeps req_valid low during the cycle reset is released
    assign req_valid_o_pcu  = running && (state == ST_REQ);
    assign req_addr_o_pcu   = pc;
    assign req_fire         = req_valid_o_pcu & req_ready_i_pcu;
    assign inst_valid_o_pcu = inst_valid_q;
    assign inst_o_pcu       = inst_q;
    assign inst_pc_o_pcu    = inst_pc_q;
    assign flush_o_pcu      = redirect & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_REQ;
            pc           <= RESET_PC;
            inst_pc_q    <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            drop         <= 1'b0;
            running      <= 1'b0;
        end else begin
            running <= 1'b1;
            case (state)
                ST_REQ: begin
                    if (redirect) begin
                        pc <= dnpc_i_pcu;
                        // the accepted request targets the old path
                        if (req_fire) begin
                            drop  <= 1'b1;
                            state <= ST_WAIT;
                        end
                    end else if (req_fire) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_valid_i_pcu) begin
                        if (redirect) begin
                            pc    <= dnpc_i_pcu;
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else if (drop) begin
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            inst_q       <= rsp_inst_i_pcu;
                            inst_pc_q    <= pc;
                            inst_valid_q <= 1'b1;
                            state        <= ST_HOLD;
                        end
                    end else if (redirect) begin
                        pc   <= dnpc_i_pcu;
                        drop <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        pc           <= dnpc_i_pcu;
                        inst_valid_q <= 1'b0;
                        state        <= ST_REQ;
                    end else if (inst_ready_i_pcu) begin
                        pc           <= pc + XLEN'(4);
                        inst_valid_q <= 1'b0;
                        state        <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

`ifdef YSYX_22040895_PCU_PERF_EN
    logic fetch_inc;
    logic drop_inc;

    assign fetch_inc = (state == ST_HOLD) && !redirect && inst_ready_i_pcu;
    assign drop_inc  = (state == ST_WAIT) && rsp_valid_i_pcu && (redirect || drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_o_pcu    <= '0;
            perf_redirect_o_pcu <= '0;
            perf_drop_o_pcu     <= '0;
        end else begin
            if (fetch_inc && (perf_fetch_o_pcu != '1))
                perf_fetch_o_pcu <= perf_fetch_o_pcu + 64'd1;
            if (redirect && (perf_redirect_o_pcu != '1))
                perf_redirect_o_pcu <= perf_redirect_o_pcu + 64'd1;
            if (drop_inc && (perf_drop_o_pcu != '1))
                perf_drop_o_pcu <= perf_drop_o_pcu + 64'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/ysyx_22040895_pcu.md
Name: ysyx_22040895_pcu

Overview:
- PC update and fetch-request unit. It is the consumer of the branch-compare result (jump_branch / dnpc) produced in EX.
- Holds the architectural fetch PC and issues fetch requests to instruction memory over a valid/ready request plus response-valid handshake.
- Applies branch redirects, discards wrong-path responses, and pulses a flush toward the IF/ID and ID/EX registers.
- Sits between EX (branch decision) and the instruction-memory port of the IFU.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
- XLEN, 64, PC/target width; matches the RegBus width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- br_valid_i_pcu  input  1  EX holds a resolved branch this cycle
- jump_branch_i_pcu  input  1  branch taken (meaningful only when br_valid_i_pcu=1)
- dnpc_i_pcu  input  XLEN  branch target
- req_valid_o_pcu  output  1  fetch request valid
- req_ready_i_pcu  input  1  memory accepts request
- req_addr_o_pcu  output  XLEN  fetch address
- rsp_valid_i_pcu  input  1  instruction returned (one per accepted request)
- rsp_inst_i_pcu  input  32  returned instruction
- inst_valid_o_pcu  output  1  instruction valid to ID
- inst_ready_i_pcu  input  1  ID accepts instruction
- inst_o_pcu  output  32  instruction to ID
- inst_pc_o_pcu  output  XLEN  PC of inst_o_pcu
- flush_o_pcu  output  1  one-cycle squash of younger pipeline stages

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; state=REQ; pending redirect cleared. All outputs 0 except req_addr_o_pcu=RESET_PC. req_valid_o_pcu rises the first cycle after reset release.
- At most one outstanding request. States:
  - REQ: req_valid=1, req_addr=pc. On req_ready=1, go to WAIT.
  - WAIT: req_valid=0; wait for rsp_valid.
  - HOLD: instruction buffered with inst_valid=1; wait for inst_ready.
- Response capture, WAIT with rsp_valid=1 and no drop flag: latch inst/pc into the output buffer, set inst_valid, go to HOLD.
- Response capture with drop flag set: discard the response, clear the drop flag, go to REQ without touching the output buffer.
- HOLD with inst_ready=1: clear inst_valid, pc<=pc+4, go to REQ. Latency: request accept -> earliest inst_valid is one cycle after rsp_valid.
- Redirect is a taken branch: br_valid=1 and jump_branch=1. On a redirect:
  - flush_o_pcu=1 for exactly that cycle (combinational from the inputs, registered nowhere else).
  - pc<=dnpc; inst_valid cleared.
  - REQ: a request accepted in the same cycle sets the drop flag and goes to WAIT. Otherwise stay in REQ with the new address the next cycle.
  - WAIT: set the drop flag; stay in WAIT.
  - HOLD: go to REQ.
- Not-taken branch (br_valid=1, jump_branch=0): no effect. jump_branch is ignored when br_valid=0.
- Redirect beats inst_ready handshake in the same cycle; the buffered instruction is squashed.
- Redirect in the same cycle rsp arrives in WAIT: the response is dropped, state goes to REQ with pc=dnpc.
- dnpc bit[1:0]!=0: the target is used as given (alignment fault is handled elsewhere).
- PC wrap: pc+4 is modulo 2^XLEN.
- req_addr/req_valid must stay stable while req_valid=1 and req_ready=0, except on a redirect, which may change the address.
- Reset mid-transaction: all state is lost. Any later rsp_valid from the old request while in REQ is ignored.

Optional Feature:
- Macro: YSYX_22040895_PCU_PERF_EN.
- Defined: adds 64-bit counters perf_fetch_o_pcu (increments on each HOLD->REQ handshake), perf_redirect_o_pcu (increments per flush_o_pcu) and perf_drop_o_pcu (increments per discarded response). All counters reset to 0 asynchronously and saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then req_ready=1, rsp after 1 cycle, inst_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 in order; inst_pc matches each address.
- req_ready held 0 for 5 cycles -> req_valid=1 and req_addr=0x80000000 stable throughout, no state change.
- Redirect (dnpc=0x80000100) while in WAIT, rsp arrives 3 cycles later -> response dropped, inst_valid stays 0, next req_addr=0x80000100, flush pulses exactly 1 cycle.
- Redirect in HOLD with inst_ready=1 same cycle -> buffered instruction squashed, pc=dnpc, no pc+4 step.
- br_valid=1, jump_branch=0, dnpc=0xdeadbeef -> flush=0, sequence unaffected. br_valid=0, jump_branch=1 -> no redirect.
- pc=0xFFFF_FFFF_FFFF_FFFC handshake -> next req_addr=0. Assert rst_n=0 in WAIT -> outputs zeroed immediately, fetch restarts at RESET_PC.
